// File: rtl/sublist_col_streamer_pkg.sv
// Shared definitions for the sublist column streamer: character geometry
// defaults, FSM state encoding and a constant-friendly clog2.
package sublist_col_streamer_pkg;

    localparam int CHAR_H_DEF = 8;
    localparam int CHAR_W_DEF = 8;
    localparam int CPSBLN_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DWELL = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sublist_col_fifo.sv
// Two-deep FIFO for returned ROM columns plus their end-of-subline flag;
// entry 0 is always the head so the output holds still while stalled.
module sublist_col_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH:0] ent0_r;
    logic [WIDTH:0] ent1_r;
    logic [1:0]     count_r;
    logic [WIDTH:0] wr_s;

    assign wr_s = {push_last, push_data};

    // Storage and occupancy; a pop with a push keeps the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_r  <= '0;
            ent1_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        ent0_r  <= wr_s;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_r <= wr_s;
                    end else if (push) begin
                        ent1_r  <= wr_s;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0_r <= ent1_r;
                        if (push) begin
                            ent1_r <= wr_s;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign head_data = ent0_r[WIDTH-1:0];
    assign head_last = ent0_r[WIDTH];
    assign valid     = (count_r != 2'd0);
    assign count     = count_r;

endmodule

// File: rtl/sublist_col_streamer.sv
// Walks a song's sublines column by column, reads NUM_LINES sublist ROMs in
// lockstep and streams packed columns out. KARAOKE_LOOP_EN: loop the song forever.
module sublist_col_streamer
    import sublist_col_streamer_pkg::*;
#(
    parameter int NUM_LINES    = 2,
    parameter int CHAR_H       = CHAR_H_DEF,
    parameter int CHAR_W       = CHAR_W_DEF,
    parameter int CPSBLN       = CPSBLN_DEF,
    parameter int NUM_SUBLINES = 64,
    parameter int DWELL        = 4,
    parameter int ADDR_W       = clog2(NUM_SUBLINES * CPSBLN * CHAR_W)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              pause,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic                              rom_en,
    input  logic [NUM_LINES*CHAR_H-1:0]       rom_data,
    output logic                              col_valid,
    input  logic                              col_ready,
    output logic [NUM_LINES*CHAR_H-1:0]       col_data,
    output logic                              col_last,
    output logic [clog2(NUM_SUBLINES)-1:0]    subline_idx,
    output logic                              busy,
    output logic                              done
);

    localparam int DATA_W     = NUM_LINES * CHAR_H;
    localparam int SUB_W      = clog2(NUM_SUBLINES);
    localparam int CHR_W      = clog2(CPSBLN);
    localparam int COL_W      = clog2(CHAR_W);
    localparam int DW_W       = clog2(DWELL + 1);
    localparam int DWELL_LAST = (DWELL > 0) ? DWELL - 1 : 0;

    state_t            state_r, state_s;
    logic [SUB_W-1:0]  sub_r, sub_s;
    logic [CHR_W-1:0]  chr_r, chr_s;
    logic [COL_W-1:0]  col_r, col_s;
    logic [DW_W-1:0]   dwell_r, dwell_s;
    logic              inflight_r;
    logic              inflight_last_r;

    logic              fetch_s;
    logic              issue_s;
    logic              col_end_s, chr_end_s, sub_end_s;
    logic              line_end_s, song_end_s;
    logic              pop_s;
    logic              credit_s;
    logic              drained_s;
    logic [2:0]        pending_s;
    logic [1:0]        fifo_count_s;
    logic              fifo_valid_s;

    assign col_end_s  = (col_r == COL_W'(CHAR_W - 1));
    assign chr_end_s  = (chr_r == CHR_W'(CPSBLN - 1));
    assign sub_end_s  = (sub_r == SUB_W'(NUM_SUBLINES - 1));
    assign line_end_s = col_end_s && chr_end_s;
    assign song_end_s = line_end_s && sub_end_s;

    // A read is in flight for exactly one cycle: the cycle its data returns and is pushed.
    assign pop_s     = fifo_valid_s && col_ready;
    assign pending_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
    assign credit_s  = (pending_s < 3'd2) || (pop_s && (pending_s < 3'd3));
    assign drained_s = !inflight_r &&
                       ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));

    // Next-state, read issue and position-counter advance.
    always_comb begin
        state_s = state_r;
        sub_s   = sub_r;
        chr_s   = chr_r;
        col_s   = col_r;
        dwell_s = dwell_r;
        fetch_s = 1'b0;
        issue_s = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fetch_s = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                fetch_s = 1'b1;
            end
            ST_DWELL: begin
                if (pause) begin
                    dwell_s = dwell_r;
                end else if (dwell_r == DW_W'(DWELL_LAST)) begin
                    dwell_s = '0;
                    state_s = ST_FETCH;
                end else begin
                    dwell_s = dwell_r + DW_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (fetch_s && !pause && credit_s && !rst) begin
            issue_s = 1'b1;
            if (!col_end_s) begin
                col_s = col_r + COL_W'(1);
            end else begin
                col_s = '0;
                if (!chr_end_s) begin
                    chr_s = chr_r + CHR_W'(1);
                end else begin
                    chr_s = '0;
                    sub_s = sub_end_s ? '0 : sub_r + SUB_W'(1);
                end
            end
            if (song_end_s) begin
`ifdef KARAOKE_LOOP_EN
                state_s = (DWELL > 0) ? ST_DWELL : ST_FETCH;
`else
                state_s = ST_DRAIN;
`endif
            end else if (line_end_s) begin
                state_s = (DWELL > 0) ? ST_DWELL : ST_FETCH;
            end else begin
                state_s = ST_FETCH;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    // State, position counters and the single-cycle in-flight tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            sub_r           <= '0;
            chr_r           <= '0;
            col_r           <= '0;
            dwell_r         <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            sub_r           <= sub_s;
            chr_r           <= chr_s;
            col_r           <= col_s;
            dwell_r         <= dwell_s;
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && line_end_s;
        end
    end

    sublist_col_fifo #(
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (rom_data),
        .push_last (inflight_last_r),
        .pop       (pop_s),
        .head_data (col_data),
        .head_last (col_last),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    assign rom_en      = issue_s;
    assign rom_addr    = ADDR_W'((int'(sub_r) * CPSBLN + int'(chr_r)) * CHAR_W + int'(col_r));
    assign col_valid   = fifo_valid_s;
    assign subline_idx = sub_r;
    assign busy        = (state_r == ST_FETCH) || (state_r == ST_DWELL);
`ifdef KARAOKE_LOOP_EN
    assign done        = 1'b0;
`else
    assign done        = (state_r == ST_DONE);
`endif

endmodule
